// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, fixed latency for every op including special cases.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL  = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd4;
    localparam logic [2:0] OP_REM  = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opd_q, opd_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            neg_q, neg_d;
    logic            neg_rem_q, neg_rem_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            a_signed, b_signed;
    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;

    logic [XLEN:0]   mul_addend, mul_sum;
    logic [XLEN:0]   div_shift, div_trial;

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic              div_by_zero, div_overflow;
    logic [XLEN-1:0]   final_res;

    // Operand conditioning: signed ops run the datapath on magnitudes and fix the sign at the end.
    always_comb begin
        a_signed = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        b_signed = op[2] ? ~op[0] : ~op[1];
        sign_a   = a_signed & a[XLEN-1];
        sign_b   = b_signed & b[XLEN-1];
        mag_a    = sign_a ? -a : a;
        mag_b    = sign_b ? -b : b;
    end

    always_comb begin
        mul_addend = lo_q[0] ? {1'b0, opd_q} : '0;
        mul_sum    = {1'b0, hi_q} + mul_addend;
        div_shift  = {hi_q, lo_q[XLEN-1]};
        div_trial  = div_shift - {1'b0, opd_q};
    end

    // Result selection; hi holds the product high half or the remainder, lo the low half or quotient.
    always_comb begin
        prod         = {hi_q, lo_q};
        prod_fix     = neg_q ? -prod : prod;
        quo_fix      = neg_q ? -lo_q : lo_q;
        rem_fix      = neg_rem_q ? -hi_q : hi_q;
        div_by_zero  = (b_q == '0);
        div_overflow = ((op_q == OP_DIV) || (op_q == OP_REM)) && (a_q == MIN_INT) && (b_q == '1);
        final_res    = '0;
        if (!op_q[2]) begin
            final_res = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (!op_q[1]) begin
            if (div_by_zero) begin
                final_res = '1;
            end else if (div_overflow) begin
                final_res = MIN_INT;
            end else begin
                final_res = quo_fix;
            end
        end else begin
            if (div_by_zero) begin
                final_res = a_q;
            end else if (div_overflow) begin
                final_res = '0;
            end else begin
                final_res = rem_fix;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opd_d     = opd_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (start && !kill) begin
                    state_d   = RUN;
                    busy_d    = 1'b1;
                    cnt_d     = CW'(XLEN-1);
                    op_d      = op;
                    a_d       = a;
                    b_d       = b;
                    hi_d      = '0;
                    opd_d     = op[2] ? mag_b : mag_a;
                    lo_d      = op[2] ? mag_a : mag_b;
                    neg_d     = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                end
            end
            RUN: begin
                if (kill) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (!op_q[2]) begin
                        hi_d = mul_sum[XLEN:1];
                        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                    end else if (!div_trial[XLEN]) begin
                        hi_d = div_trial[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                    if (cnt_q == '0) begin
                        state_d = FINISH;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (!kill) begin
                    done_d   = 1'b1;
                    result_d = final_res;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opd_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opd_q     <= opd_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: issued ops push expected results from an
// arithmetic reference model; a negedge monitor pops and compares on each done.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] exp;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          busy_run = 0;
    logic        prev_busy = 1'b0;
    logic [31:0] last_exp = '0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .kill   (kill),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference: RV32M semantics via 64-bit integer arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        longint      uy = longint'({32'b0, y});
        logic [63:0] p;
        logic [31:0] r;
        logic        ovf;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        r = '0;
        case (f)
            3'd0: begin p = sx * sy; r = p[31:0]; end
            3'd1: begin p = sx * sy; r = p[63:32]; end
            3'd2: begin p = sx * uy; r = p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
            3'd4: begin
                if (y == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = 32'h8000_0000;
                else begin p = sx / sy; r = p[31:0]; end
            end
            3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) r = x;
                else if (ovf) r = '0;
                else begin p = sx % sy; r = p[31:0]; end
            end
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e.op  = f;
        e.exp = refModel(f, x, y);
        e.due = cyc + 34;
        sbq.push_back(e);
        last_exp = e.exp;
        op    = f;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout: got no done, expected done within 100 cycles");
            sbq.delete();
        end
    endtask

    task automatic quietCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every done must match the oldest outstanding op, on time.
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_run = prev_busy ? busy_run + 1 : 1;
        prev_busy = busy;
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done: got done=1 result=%h, expected no done", result);
            end else begin
                e = sbq.pop_front();
                checkOutput($sformatf("result_op%0d", e.op), result, e.exp);
                checkOutput("latency", 32'(cyc), 32'(e.due));
                checkOutput("busy_len", 32'(busy_run), 32'd33);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] da [12];
        logic [31:0] db [12];
        logic [2:0]  dop[12];
        logic [31:0] special[4];
        logic [31:0] x, y;

        rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
        quietCycles(3);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        rst = 1'b0;
        quietCycles(2);

        dop = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
        da  = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        db  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2, 32'd2, 32'd2,
                32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 12; i++) begin
            applyStimulus(dop[i], da[i], db[i]);
            waitDone();
        end

        special = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1};
        for (int i = 0; i < 40; i++) begin
            x = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 2) == 0) y = y >> $urandom_range(0, 31);
            applyStimulus(3'($urandom_range(0, 7)), x, y);
            waitDone();
        end

        // Second start mid-op must be ignored.
        applyStimulus(3'd5, 32'd100, 32'd7);
        quietCycles(9);
        op = 3'd0; a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone();
        quietCycles(40);
        checkOutput("second_start_result", result, 32'd14);

        // Start offered in the FINISH cycle must be ignored.
        applyStimulus(3'd0, 32'd5, 32'd6);
        quietCycles(32);
        op = 3'd0; a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("finish_start_busy", {31'b0, busy}, 32'd0);
        waitDone();
        quietCycles(40);
        checkOutput("finish_start_result", result, 32'd30);

        // Kill and start together in IDLE: kill wins.
        kill = 1'b1; start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
        @(negedge clk);
        kill = 1'b0; start = 1'b0;
        checkOutput("kill_start_busy", {31'b0, busy}, 32'd0);
        quietCycles(40);

        // Kill mid-op: result keeps the previous value, no done.
        begin
            logic [31:0] keep;
            keep = last_exp;
            applyStimulus(3'd5, 32'd1000, 32'd3);
            quietCycles(11);
            kill = 1'b1;
            @(negedge clk);
            kill = 1'b0;
            sbq.delete();
            last_exp = keep;
            checkOutput("kill_busy", {31'b0, busy}, 32'd0);
            checkOutput("kill_done", {31'b0, done}, 32'd0);
            checkOutput("kill_result", result, keep);
            quietCycles(40);
            checkOutput("kill_result_later", result, keep);
        end

        // Reset mid-op clears everything at once.
        applyStimulus(3'd0, 32'd123, 32'd456);
        quietCycles(19);
        rst = 1'b1;
        #1;
        sbq.delete();
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst_done", {31'b0, done}, 32'd0);
        checkOutput("midrst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        quietCycles(40);
        checkOutput("midrst_result_later", result, 32'd0);

        applyStimulus(3'd0, 32'd3, 32'd4);
        waitDone();
        quietCycles(3);
        checkOutput("post_reset_mul", result, 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
